// File: rtl/font5_adc_pkg.sv
// Shared definitions for the clk357 ADC front end.
//   - board default BITFLIP masks (sign-bit inversion already folded in)
//   - FSM state encoding for the window controller
//   - saturating arithmetic helpers on 64-bit signed values clamped to w bits
package font5_adc_pkg;

   localparam logic [12:0] SIGN_INV    = 13'h1000;
   localparam logic [12:0] BITFLIP_CH1 = 13'b1011010000101 ^ SIGN_INV;
   localparam logic [12:0] BITFLIP_CH2 = 13'b0101110001000 ^ SIGN_INV;
   localparam logic [12:0] BITFLIP_CH4 = 13'b0111100000000 ^ SIGN_INV;
   localparam logic [12:0] BITFLIP_CH5 = 13'b0100110011010 ^ SIGN_INV;

   // Channel 0 in the LSBs, matching the BITFLIP parameter layout.
   localparam logic [51:0] BITFLIP_BOARD = {BITFLIP_CH5, BITFLIP_CH4, BITFLIP_CH2, BITFLIP_CH1};

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDelay = 2'd1,
      StInteg = 2'd2,
      StDone  = 2'd3
   } fsm_state_e;

   function automatic logic signed [63:0] sat_max(input int unsigned w);
      return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int unsigned w);
      return -(64'sd1 <<< (w - 32'd1));
   endfunction

   function automatic logic sat_ovf(input logic signed [63:0] v, input int unsigned w);
      return (v > sat_max(w)) || (v < sat_min(w));
   endfunction

   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                    input int unsigned w);
      if (v > sat_max(w)) begin
         return sat_max(w);
      end else if (v < sat_min(w)) begin
         return sat_min(w);
      end
      return v;
   endfunction

   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned w);
      return sat_clamp(a + b, w);
   endfunction

endpackage

// File: rtl/adc_chan_frontend_if.sv
// Data/control bundle of the ADC channel front end.
//   master: register bank / capture side (drives samples, pedestal, window controls)
//   slave : the front end itself (drives decoded samples, window sums and status)
interface adc_chan_frontend_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned DW    = 13,
   parameter int unsigned ACC_W = 20,
   parameter int unsigned CW    = 7
);

   logic [N_CH*DW-1:0]    adc_raw;
   logic [N_CH*DW-1:0]    offset;
   logic                  trig;
   logic [CW-1:0]         win_dly;
   logic [CW-1:0]         win_len;
   logic [N_CH*DW-1:0]    dec_out;
   logic [N_CH*ACC_W-1:0] acc_out;
   logic                  acc_valid;
   logic                  busy;
   logic [N_CH-1:0]       sat_flags;

   modport master (
      output adc_raw, offset, trig, win_dly, win_len,
      input  dec_out, acc_out, acc_valid, busy, sat_flags
   );

   modport slave (
      input  adc_raw, offset, trig, win_dly, win_len,
      output dec_out, acc_out, acc_valid, busy, sat_flags
   );

endinterface

// File: rtl/adc_chan_lane.sv
// One ADC channel: bit-flip decode, saturating pedestal subtract, window accumulator.
//   clk357, rst : clock, asynchronous active-high reset
//   adc_raw     : raw captured word
//   offset      : signed pedestal
//   clr         : window start, zeroes accumulator and sticky flag
//   integ       : add the current dec_out into the accumulator
//   load        : copy accumulator to acc_out
//   dec_out     : decoded, pedestal-subtracted sample (2-cycle latency)
//   acc_out     : held window sum
//   sat         : sticky saturation flag for the current window
module adc_chan_lane
   import font5_adc_pkg::*;
#(
   parameter int unsigned   DW    = 13,
   parameter int unsigned   ACC_W = 20,
   parameter logic [DW-1:0] MASK  = '0
) (
   input  logic                    clk357,
   input  logic                    rst,
   input  logic [DW-1:0]           adc_raw,
   input  logic signed [DW-1:0]    offset,
   input  logic                    clr,
   input  logic                    integ,
   input  logic                    load,
   output logic signed [DW-1:0]    dec_out,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    sat
);

   logic signed [DW-1:0]    d1_q;
   logic signed [DW-1:0]    dec_q, dec_d;
   logic                    dec_sat_q;
   logic signed [DW:0]      diff;
   logic                    sub_ovf;
   logic signed [63:0]      acc_sum;
   logic                    acc_ovf;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] acc_out_q;
   logic                    sat_q;

   always_comb begin
      // One extra bit is enough to hold any DW-bit difference exactly.
      diff    = (DW+1)'(d1_q) - (DW+1)'(offset);
      sub_ovf = sat_ovf(64'(diff), DW);
      dec_d   = DW'(sat_clamp(64'(diff), DW));
      acc_sum = 64'(acc_q) + 64'(dec_q);
      acc_ovf = sat_ovf(acc_sum, ACC_W);
      acc_d   = ACC_W'(sat_add(64'(acc_q), 64'(dec_q), ACC_W));
   end

   always_ff @(posedge clk357 or posedge rst) begin
      if (rst) begin
         d1_q      <= '0;
         dec_q     <= '0;
         dec_sat_q <= 1'b0;
         acc_q     <= '0;
         acc_out_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         d1_q      <= adc_raw ^ MASK;
         dec_q     <= dec_d;
         dec_sat_q <= sub_ovf;
         if (clr) begin
            acc_q <= '0;
            sat_q <= 1'b0;
         end else if (integ) begin
            // A clamped pedestal subtract only counts once it lands in the window.
            acc_q <= acc_d;
            sat_q <= sat_q | dec_sat_q | acc_ovf;
         end
         if (load) begin
            acc_out_q <= acc_q;
         end
      end
   end

   assign dec_out = dec_q;
   assign acc_out = acc_out_q;
   assign sat     = sat_q;

endmodule

// File: rtl/adc_chan_frontend.sv
// N-channel ADC front end: per-channel decode/pedestal lanes plus a shared
// trigger/delay/length window controller.
//   clk357 : sample clock (only clock)
//   rst    : asynchronous active-high reset
//   bus    : slave side of adc_chan_frontend_if (samples, pedestals, window
//            controls in; decoded samples, window sums, acc_valid, busy, sat_flags out)
module adc_chan_frontend
   import font5_adc_pkg::*;
#(
   parameter int unsigned          N_CH    = 4,
   parameter int unsigned          DW      = 13,
   parameter int unsigned          ACC_W   = 20,
   parameter int unsigned          CW      = 7,
   parameter logic [N_CH*DW-1:0]   BITFLIP = {N_CH{13'h0}}
) (
   input  logic                 clk357,
   input  logic                 rst,
   adc_chan_frontend_if.slave   bus
);

   fsm_state_e       state_q, state_d;
   logic [CW-1:0]    dly_q, dly_d;
   logic [CW-1:0]    len_q, len_d;
   logic             start, integ, load;
   logic             acc_valid_q, busy_q;

   logic [N_CH*DW-1:0]    dec_w;
   logic [N_CH*ACC_W-1:0] acc_w;
   logic [N_CH-1:0]       sat_w;

   // State and counter register
   always_ff @(posedge clk357 or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         dly_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         len_q   <= len_d;
      end
   end

   // Next state. Zero delay and/or zero length skip the corresponding states.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      len_d   = len_q;
      case (state_q)
         StIdle: begin
            if (bus.trig) begin
               dly_d = bus.win_dly;
               len_d = bus.win_len;
               if (bus.win_dly != '0) begin
                  state_d = StDelay;
               end else if (bus.win_len != '0) begin
                  state_d = StInteg;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDelay: begin
            dly_d = dly_q - CW'(1);
            if (dly_q <= CW'(1)) begin
               state_d = (len_q != '0) ? StInteg : StDone;
            end
         end
         StInteg: begin
            len_d = len_q - CW'(1);
            if (len_q <= CW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Lane controls
   always_comb begin
      start = (state_q == StIdle) && bus.trig;
      integ = (state_q == StInteg);
      load  = (state_q == StDone);
   end

   // acc_valid lands together with the acc_out update; busy trails state by one
   // cycle so it drops with acc_valid.
   always_ff @(posedge clk357 or posedge rst) begin
      if (rst) begin
         acc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         acc_valid_q <= load;
         busy_q      <= (state_q != StIdle);
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_lane
      adc_chan_lane #(
         .DW    (DW),
         .ACC_W (ACC_W),
         .MASK  (BITFLIP[c*DW +: DW])
      ) u_lane (
         .clk357  (clk357),
         .rst     (rst),
         .adc_raw (bus.adc_raw[c*DW +: DW]),
         .offset  (bus.offset[c*DW +: DW]),
         .clr     (start),
         .integ   (integ),
         .load    (load),
         .dec_out (dec_w[c*DW +: DW]),
         .acc_out (acc_w[c*ACC_W +: ACC_W]),
         .sat     (sat_w[c])
      );
   end

   assign bus.dec_out   = dec_w;
   assign bus.acc_out   = acc_w;
   assign bus.sat_flags = sat_w;
   assign bus.acc_valid = acc_valid_q;
   assign bus.busy      = busy_q;

endmodule
